// File: rtl/jk_bank_arbiter.sv
// Three-requester round-robin arbiter in front of a bank of JK storage bits.
// Each granted command runs IDLE -> APPLY -> DONE and updates one addressed bit.
module jk_bank_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [2:0]        Req,
  input  logic [2:0]        J,
  input  logic [2:0]        K,
  input  logic [3*AW-1:0]   Addr,
  output logic [2:0]        Gnt,
  output logic              Done,
  output logic              Err,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qbar
);

  localparam int unsigned NREQ = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [2:0]        gnt_q;
  logic              done_q;
  logic              err_q;
  logic              j_q;
  logic              k_q;
  logic [AW-1:0]     addr_q;
  logic [WIDTH-1:0]  q_q;

  logic              win_vld;
  logic [1:0]        win_idx;
  logic              win_j;
  logic              win_k;
  logic [AW-1:0]     win_addr;
  logic [1:0]        ptr_d;
  logic              addr_ok;
  logic [WIDTH-1:0]  q_d;

  // Requester index at a given offset from the round-robin pointer, modulo 3.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = 3'(base) + 3'(off);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Winner search: walk offsets from last to first so the lowest offset wins.
  always_comb begin
    logic [1:0] cand;
    win_vld  = 1'b0;
    win_idx  = 2'd0;
    cand     = 2'd0;
    for (int o = int'(NREQ) - 1; o >= 0; o--) begin
      cand = rr_idx(ptr_q, 2'(o));
      if (Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_j    = 1'b0;
    win_k    = 1'b0;
    win_addr = '0;
    for (int r = 0; r < int'(NREQ); r++) begin
      if (2'(r) == win_idx) begin
        win_j    = J[r];
        win_k    = K[r];
        win_addr = Addr[r*int'(AW) +: AW];
      end
    end
    ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
  end

  // JK update of the addressed bit; out-of-range addresses leave the bank alone.
  always_comb begin
    addr_ok = (32'(addr_q) < WIDTH);
    q_d     = q_q;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      if (addr_ok && (32'(addr_q) == b)) begin
        case ({j_q, k_q})
          2'b01:   q_d[b] = 1'b0;
          2'b10:   q_d[b] = 1'b1;
          2'b11:   q_d[b] = ~q_q[b];
          default: q_d[b] = q_q[b];
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 3'b000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      addr_q  <= '0;
      q_q     <= '0;
    end else begin
      gnt_q  <= 3'b000;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q <= S_APPLY;
            gnt_q   <= 3'b001 << win_idx;
            j_q     <= win_j;
            k_q     <= win_k;
            addr_q  <= win_addr;
            ptr_q   <= ptr_d;
          end
        end
        S_APPLY: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          err_q   <= ~addr_ok;
          q_q     <= q_d;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Gnt  = gnt_q;
  assign Done = done_q;
  assign Err  = err_q;
  assign Q    = q_q;
  assign Qbar = ~q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: a round-robin/JK reference model queues
// expected completions; a negedge monitor checks every Done pulse against them.
module tb_jk_bank_arbiter;

  localparam int unsigned W  = 6;
  localparam int unsigned AW = 3;

  logic            clk = 1'b0;
  logic            clr;
  logic [2:0]      req;
  logic [2:0]      j;
  logic [2:0]      k;
  logic [3*AW-1:0] addr;
  logic [2:0]      gnt;
  logic            done;
  logic            err;
  logic [W-1:0]    q;
  logic [W-1:0]    qbar;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(W), .AW(AW)) dut (
    .Clk  (clk),
    .Clr  (clr),
    .Req  (req),
    .J    (j),
    .K    (k),
    .Addr (addr),
    .Gnt  (gnt),
    .Done (done),
    .Err  (err),
    .Q    (q),
    .Qbar (qbar)
  );

  typedef struct packed {
    logic [2:0]   gnt;
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            m_ptr  = 0;
  logic [W-1:0]  m_q    = '0;
  logic [2:0]    prev_gnt = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: first requester at or after the pointer wins; JK applied to a bit index.
  task automatic model_push(input logic [2:0] r, input logic [2:0] jj, input logic [2:0] kk,
                            input logic [3*AW-1:0] aa);
    int         w;
    int         c;
    int         a;
    exp_t       e;
    w = -1;
    for (int o = 0; o < 3; o++) begin
      c = (m_ptr + o) % 3;
      if (w < 0 && r[c]) w = c;
    end
    if (w < 0) return;
    a = int'((aa >> (w * 3)) & 9'h7);
    e.gnt = 3'(1 << w);
    e.err = (a >= int'(W));
    if (!e.err) begin
      case ({jj[w], kk[w]})
        2'b01:   m_q[a] = 1'b0;
        2'b10:   m_q[a] = 1'b1;
        2'b11:   m_q[a] = ~m_q[a];
        default: m_q[a] = m_q[a];
      endcase
    end
    e.q   = m_q;
    m_ptr = (w + 1) % 3;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
  task automatic issue(input logic [2:0] r, input logic [2:0] jj, input logic [2:0] kk,
                       input logic [3*AW-1:0] aa);
    bit seen;
    model_push(r, jj, kk, aa);
    req  = r;
    j    = jj;
    k    = kk;
    addr = aa;
    if (r == 3'b000) begin
      @(negedge clk);
      return;
    end
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant within 4 cycles for req 0x%0h", r);
    end
    req = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: Qbar invariant every cycle, scoreboard pop on every Done pulse.
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] nq;
    nq = ~q;
    chk("qbar_inv", 32'(qbar), 32'(nq));
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done with no pending command at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("gnt_before_done", 32'(prev_gnt), 32'(e.gnt));
        chk("q_at_done", 32'(q), 32'(e.q));
        chk("err_at_done", 32'(err), 32'(e.err));
        chk("gnt_zero_in_done", 32'(gnt), 32'(0));
      end
    end else begin
      chk("err_without_done", 32'(err), 32'(0));
    end
    prev_gnt = gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]      r;
    logic [2:0]      jj;
    logic [2:0]      kk;
    logic [3*AW-1:0] aa;

    clr  = 1'b0;
    req  = 3'b000;
    j    = 3'b000;
    k    = 3'b000;
    addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_qbar", 32'(qbar), 32'(6'h3F));
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));

    // Release reset and request in the same cycle: first IDLE samples normally.
    clr = 1'b1;
    issue(3'b001, 3'b001, 3'b000, 9'(5));
    issue(3'b010, 3'b010, 3'b010, 9'(5 << 3));
    issue(3'b010, 3'b010, 3'b010, 9'(5 << 3));
    issue(3'b001, 3'b001, 3'b000, 9'(7));
    for (int b = 0; b < int'(W); b++) issue(3'b001, 3'b001, 3'b000, 9'(b));
    issue(3'b100, 3'b000, 3'b000, 9'(2 << 6));

    // Reset during APPLY of a set to bit 3: aborted, bank cleared, no Done.
    req  = 3'b001;
    j    = 3'b001;
    k    = 3'b000;
    addr = 9'(3);
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'(3'b001));
    clr = 1'b0;
    @(negedge clk);
    chk("abort_q", 32'(q), 32'(0));
    chk("abort_qbar", 32'(qbar), 32'(6'h3F));
    chk("abort_gnt_clr", 32'(gnt), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    clr   = 1'b1;
    req   = 3'b000;
    m_ptr = 0;
    m_q   = '0;

    // All three requesting continuously: four back-to-back commands.
    req  = 3'b111;
    j    = 3'b000;
    k    = 3'b000;
    addr = '0;
    repeat (4) model_push(3'b111, 3'b000, 3'b000, 9'(0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    req = 3'b000;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      r  = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) r = 3'b000;
      jj = 3'($urandom_range(0, 7));
      kk = 3'($urandom_range(0, 7));
      aa = 9'($urandom_range(0, 511));
      issue(r, jj, kk, aa);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
